// File: rtl/packet_parser_pkg.sv
// Shared types and constants for the packet_parser byte-stream frame parser.
package packet_parser_pkg;

    localparam logic [7:0] PKT_SYNC_DEFAULT = 8'hA5;

    typedef enum logic [1:0] {
        HUNT     = 2'd0,
        GET_HI   = 2'd1,
        GET_LO   = 2'd2,
        GET_CSUM = 2'd3
    } pp_state_e;

    // Frame check byte: XOR of the two payload bytes.
    function automatic logic [7:0] frame_csum(input logic [7:0] hi, input logic [7:0] lo);
        return hi ^ lo;
    endfunction

endpackage

// File: rtl/packet_parser.sv
// Sync-hunting byte-stream parser producing a 16-bit big-endian word per frame.
// Define PACKET_PARSER_CHECKSUM_EN to require a trailing HI^LO check byte.
module packet_parser
    import packet_parser_pkg::*;
#(
    parameter logic [7:0] SYNC_BYTE = PKT_SYNC_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  packet_in,
    output logic [15:0] parsed_data,
    output logic        packet_valid
);

    pp_state_e   state_r;
    pp_state_e   state_nxt_s;
    logic [7:0]  hi_r;
    logic [7:0]  hi_nxt_s;
    logic [15:0] data_r;
    logic [15:0] data_nxt_s;
    logic        valid_r;
    logic        valid_nxt_s;
`ifdef PACKET_PARSER_CHECKSUM_EN
    logic [7:0]  lo_r;
    logic [7:0]  lo_nxt_s;
`endif

    // Next-state and next-output decode for the frame FSM.
    always_comb begin
        state_nxt_s = state_r;
        hi_nxt_s    = hi_r;
        data_nxt_s  = data_r;
        valid_nxt_s = 1'b0;
`ifdef PACKET_PARSER_CHECKSUM_EN
        lo_nxt_s    = lo_r;
`endif
        case (state_r)
            HUNT: begin
                if (packet_in == SYNC_BYTE) begin
                    state_nxt_s = GET_HI;
                end else begin
                    state_nxt_s = HUNT;
                end
            end
            GET_HI: begin
                hi_nxt_s    = packet_in;
                state_nxt_s = GET_LO;
            end
            GET_LO: begin
`ifdef PACKET_PARSER_CHECKSUM_EN
                lo_nxt_s    = packet_in;
                state_nxt_s = GET_CSUM;
`else
                data_nxt_s  = {hi_r, packet_in};
                valid_nxt_s = 1'b1;
                state_nxt_s = HUNT;
`endif
            end
`ifdef PACKET_PARSER_CHECKSUM_EN
            GET_CSUM: begin
                // A bad check byte drops the frame without touching parsed_data.
                if (packet_in == frame_csum(hi_r, lo_r)) begin
                    data_nxt_s  = {hi_r, lo_r};
                    valid_nxt_s = 1'b1;
                end else begin
                    valid_nxt_s = 1'b0;
                end
                state_nxt_s = HUNT;
            end
`endif
            default: begin
                state_nxt_s = HUNT;
            end
        endcase
    end

    // State, payload and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= HUNT;
            hi_r    <= 8'h00;
            data_r  <= 16'h0000;
            valid_r <= 1'b0;
`ifdef PACKET_PARSER_CHECKSUM_EN
            lo_r    <= 8'h00;
`endif
        end else begin
            state_r <= state_nxt_s;
            hi_r    <= hi_nxt_s;
            data_r  <= data_nxt_s;
            valid_r <= valid_nxt_s;
`ifdef PACKET_PARSER_CHECKSUM_EN
            lo_r    <= lo_nxt_s;
`endif
        end
    end

    assign parsed_data  = data_r;
    assign packet_valid = valid_r;

endmodule

// File: tb/tb_packet_parser.sv
// Randomised self-checking bench for packet_parser against a queue-based frame model.
module tb_packet_parser;

    localparam logic [7:0] SYNC = 8'hA5;
`ifdef PACKET_PARSER_CHECKSUM_EN
    localparam int FRAME_LEN = 4;
    localparam bit CSUM_EN   = 1'b1;
`else
    localparam int FRAME_LEN = 3;
    localparam bit CSUM_EN   = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  packet_in = 8'h00;
    logic [15:0] parsed_data;
    logic        packet_valid;

    int vectors     = 0;
    int miscompares = 0;
    int strobes     = 0;

    logic [7:0]  frame_q[$];
    logic [15:0] m_data  = 16'h0000;
    logic        m_valid = 1'b0;

    packet_parser #(.SYNC_BYTE(SYNC)) dut (
        .clk          (clk),
        .rst          (rst),
        .packet_in    (packet_in),
        .parsed_data  (parsed_data),
        .packet_valid (packet_valid)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        vectors++;
        if (obs !== exp) begin
            miscompares++;
            $display("FAIL %s: observed %h expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Reference: collect bytes of the current frame; evaluate once the frame is full.
    task automatic model_step(input logic [7:0] b, input logic r);
        m_valid = 1'b0;
        if (r) begin
            frame_q.delete();
            m_data = 16'h0000;
        end else if (frame_q.size() == 0) begin
            if (b == SYNC) frame_q.push_back(b);
        end else begin
            frame_q.push_back(b);
            if (frame_q.size() == FRAME_LEN) begin
                if (!CSUM_EN || ((frame_q[1] ^ frame_q[2]) == frame_q[FRAME_LEN-1])) begin
                    m_data  = {frame_q[1], frame_q[2]};
                    m_valid = 1'b1;
                end
                frame_q.delete();
            end
        end
    endtask

    task automatic step(input logic [7:0] b, input logic r);
        packet_in = b;
        rst       = r;
        @(posedge clk);
        model_step(b, r);
        @(negedge clk);
        if (packet_valid === 1'b1) strobes++;
        check("valid", {15'h0000, packet_valid}, {15'h0000, m_valid});
        check("data", parsed_data, m_data);
    endtask

    task automatic send_frame(input logic [7:0] hi, input logic [7:0] lo, input bit good);
        step(SYNC, 1'b0);
        step(hi, 1'b0);
        step(lo, 1'b0);
        if (CSUM_EN) step(good ? (hi ^ lo) : ~(hi ^ lo), 1'b0);
    endtask

    initial begin
        logic [7:0] hi;
        logic [7:0] lo;
        @(negedge clk);

        // Reset then idle
        step(8'h00, 1'b1);
        for (int i = 0; i < 10; i++) step(8'h00, 1'b0);
        check("idle_data", parsed_data, 16'h0000);

`ifndef PACKET_PARSER_CHECKSUM_EN
        // Basic frame, then held last byte must not re-strobe
        step(8'hA5, 1'b0);
        step(8'h3C, 1'b0);
        step(8'hFF, 1'b0);
        check("basic_valid", {15'h0000, packet_valid}, 16'h0001);
        check("basic_data", parsed_data, 16'h3CFF);
        for (int i = 0; i < 4; i++) step(8'hFF, 1'b0);
        check("hold_data", parsed_data, 16'h3CFF);

        // Sync as data, then back-to-back frame
        step(8'hA5, 1'b0);
        step(8'hA5, 1'b0);
        step(8'h12, 1'b0);
        check("sync_data", parsed_data, 16'hA512);
        step(8'hA5, 1'b0);
        step(8'h00, 1'b0);
        step(8'h01, 1'b0);
        check("b2b_valid", {15'h0000, packet_valid}, 16'h0001);
        check("b2b_data", parsed_data, 16'h0001);
`else
        step(8'hA5, 1'b0);
        step(8'h3C, 1'b0);
        step(8'hFF, 1'b0);
        step(8'hC3, 1'b0);
        check("csum_valid", {15'h0000, packet_valid}, 16'h0001);
        check("csum_data", parsed_data, 16'h3CFF);
        step(8'hA5, 1'b0);
        step(8'h11, 1'b0);
        step(8'h22, 1'b0);
        step(8'h00, 1'b0);
        check("bad_csum_valid", {15'h0000, packet_valid}, 16'h0000);
        check("bad_csum_data", parsed_data, 16'h3CFF);
`endif

        // Reset mid-frame aborts the partial frame
        step(8'hA5, 1'b0);
        step(8'h3C, 1'b0);
        step(8'h00, 1'b1);
        step(8'hFF, 1'b0);
        step(8'h00, 1'b0);
        check("abort_data", parsed_data, 16'h0000);

        // Randomised mix of noise, frames, partial frames and resets
        for (int n = 0; n < 600; n++) begin
            case ($urandom_range(0, 6))
                0, 1: step(8'($urandom), 1'b0);
                2, 3, 4: begin
                    hi = ($urandom_range(0, 3) == 0) ? SYNC : 8'($urandom);
                    lo = ($urandom_range(0, 3) == 0) ? SYNC : 8'($urandom);
                    send_frame(hi, lo, $urandom_range(0, 2) != 0);
                end
                5: begin
                    step(SYNC, 1'b0);
                    step(8'($urandom), 1'b0);
                end
                default: step(8'($urandom), $urandom_range(0, 4) == 0);
            endcase
        end

        check("strobes_seen", {15'h0000, strobes > 50}, 16'h0001);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
